// File: rtl/llc_sweep_ctrl.sv
// LLC init-reset / flush sweep sequencer: issues one op per set into the pipeline
// issue slot, tracks unacknowledged sets and raises the matching stall.
module llc_sweep_ctrl #(
    parameter int unsigned SET_BITS        = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned NUM_SETS       = 2 ** SET_BITS,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_state,
    input  logic                flush_req_valid,
    output logic                flush_req_ready,
    output logic                sweep_valid,
    input  logic                sweep_ready,
    output logic [SET_BITS-1:0] sweep_set,
    output logic                sweep_is_rst,
    input  logic                sweep_ack,
    output logic                rst_stall,
    output logic                flush_stall,
    output logic                rst_done,
    output logic                flush_done,
    output logic [CNT_W-1:0]    outstanding,
    output logic                proto_err
);

    typedef enum logic [2:0] {
        ST_START,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE,
        ST_IDLE
    } state_t;

    typedef enum logic {
        MODE_FLUSH = 1'b0,
        MODE_RST   = 1'b1
    } mode_t;

    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [SET_BITS-1:0] set_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                rst_stall_d, flush_stall_d, perr_d;
    logic                valid_d, ready_d, rst_done_d, flush_done_d;
    logic                issue, ack_seen, ack_ok;

    assign issue        = sweep_valid && sweep_ready;
    assign sweep_is_rst = (mode_q == MODE_RST);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_START;
            mode_q          <= MODE_RST;
            sweep_set       <= '0;
            outstanding     <= '0;
            rst_stall       <= 1'b1;
            flush_stall     <= 1'b0;
            proto_err       <= 1'b0;
            sweep_valid     <= 1'b0;
            flush_req_ready <= 1'b0;
            rst_done        <= 1'b0;
            flush_done      <= 1'b0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            sweep_set       <= set_d;
            outstanding     <= cnt_d;
            rst_stall       <= rst_stall_d;
            flush_stall     <= flush_stall_d;
            proto_err       <= perr_d;
            sweep_valid     <= valid_d;
            flush_req_ready <= ready_d;
            rst_done        <= rst_done_d;
            flush_done      <= flush_done_d;
        end
    end

    // Next-state, credit counter and next registered outputs
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        set_d         = sweep_set;
        cnt_d         = outstanding;
        rst_stall_d   = rst_stall;
        flush_stall_d = flush_stall;
        perr_d        = proto_err;

        // Acks in the START cycle belong to a sweep that was abandoned
        ack_seen = sweep_ack && (state_q != ST_START);
        ack_ok   = ack_seen && (outstanding != '0);
        if (ack_seen && (outstanding == '0)) begin
            perr_d = 1'b1;
        end

        if (issue && !ack_ok) begin
            cnt_d = outstanding + CNT_W'(1);
        end else if (!issue && ack_ok) begin
            cnt_d = outstanding - CNT_W'(1);
        end

        case (state_q)
            ST_START: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (issue) begin
                    set_d = sweep_set + SET_BITS'(1);
                    if (sweep_set == LAST_SET) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (mode_q == MODE_RST) begin
                    rst_stall_d = 1'b0;
                end else begin
                    flush_stall_d = 1'b0;
                end
            end
            ST_IDLE: begin
                if (flush_req_valid && flush_req_ready) begin
                    mode_d        = MODE_FLUSH;
                    flush_stall_d = 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            default: state_d = ST_START;
        endcase

        if (rst_state) begin
            state_d       = ST_START;
            mode_d        = MODE_RST;
            set_d         = '0;
            cnt_d         = '0;
            rst_stall_d   = 1'b1;
            flush_stall_d = 1'b0;
            perr_d        = 1'b0;
        end

        valid_d      = (state_d == ST_ISSUE) && (cnt_d < CNT_MAX);
        ready_d      = (state_d == ST_IDLE);
        rst_done_d   = (state_d == ST_DONE) && (mode_d == MODE_RST);
        flush_done_d = (state_d == ST_DONE) && (mode_d == MODE_FLUSH);
    end

endmodule

// File: tb/tb_llc_sweep_ctrl.sv
// Directed bench for llc_sweep_ctrl with 16 sets and 4 credits.
module tb_llc_sweep_ctrl;

    localparam int unsigned SET_BITS = 4;
    localparam int unsigned MAX_OUT  = 4;
    localparam int unsigned CNT_W    = $clog2(MAX_OUT + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rst_state = 1'b0;
    logic                flush_req_valid = 1'b0;
    logic                flush_req_ready;
    logic                sweep_valid;
    logic                sweep_ready = 1'b0;
    logic [SET_BITS-1:0] sweep_set;
    logic                sweep_is_rst;
    logic                sweep_ack = 1'b0;
    logic                rst_stall;
    logic                flush_stall;
    logic                rst_done;
    logic                flush_done;
    logic [CNT_W-1:0]    outstanding;
    logic                proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    llc_sweep_ctrl #(.SET_BITS(SET_BITS), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .rst_state(rst_state),
        .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready),
        .sweep_valid(sweep_valid), .sweep_ready(sweep_ready), .sweep_set(sweep_set),
        .sweep_is_rst(sweep_is_rst), .sweep_ack(sweep_ack),
        .rst_stall(rst_stall), .flush_stall(flush_stall),
        .rst_done(rst_done), .flush_done(flush_done),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_state = 1'b0; flush_req_valid = 1'b0; sweep_ready = 1'b0; sweep_ack = 1'b0;
        step(); step();
        n_checks++; if (rst_stall !== 1'b1) begin n_fail++; $display("FAIL reset_rst_stall got %b want 1", rst_stall); end
        n_checks++; if (flush_stall !== 1'b0) begin n_fail++; $display("FAIL reset_flush_stall got %b want 0", flush_stall); end
        n_checks++; if (sweep_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", sweep_valid); end
        n_checks++; if (flush_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", flush_req_ready); end
        n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err got %b want 0", proto_err); end
        n_checks++; if (sweep_set !== 4'd0 || sweep_is_rst !== 1'b1) begin n_fail++; $display("FAIL reset_set got set=%0d is_rst=%b want 0/1", sweep_set, sweep_is_rst); end
        n_checks++; if (rst_done !== 1'b0 || flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b%b want 00", rst_done, flush_done); end
        rst = 1'b0;
        step();
        n_checks++; if (sweep_valid !== 1'b1 || rst_stall !== 1'b1) begin n_fail++; $display("FAIL start_to_issue got valid=%b stall=%b want 1/1", sweep_valid, rst_stall); end
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    // Full init sweep with each ack returned 3 cycles after its issue.
    task automatic test_init_sweep();
        logic [2:0] pipe = 3'b000;
        int issued = 0, dones = 0, bad_set = 0, stall_bad = 0;
        logic prev_done = 1'b0, hs;
        sweep_ready = 1'b1;
        n_checks++; if (sweep_valid !== 1'b0) begin n_fail++; $display("FAIL init_start_valid got %b want 0", sweep_valid); end
        for (int c = 0; c < 40; c++) begin
            if (prev_done) begin
                n_checks++; if (rst_stall !== 1'b0 || flush_req_ready !== 1'b1) begin n_fail++; $display("FAIL init_after_done got stall=%b ready=%b want 0/1", rst_stall, flush_req_ready); end
            end
            prev_done = rst_done;
            if (rst_done) begin
                dones++;
                if (rst_stall !== 1'b1) stall_bad++;
            end
            hs = sweep_valid && sweep_ready;
            if (hs) begin
                if (sweep_set !== SET_BITS'(issued) || sweep_is_rst !== 1'b1) bad_set++;
                issued++;
            end
            sweep_ack = pipe[2];
            pipe = {pipe[1:0], hs};
            step();
        end
        sweep_ack = 1'b0;
        n_checks++; if (issued != 16) begin n_fail++; $display("FAIL init_issue_count got %0d want 16", issued); end
        n_checks++; if (bad_set != 0) begin n_fail++; $display("FAIL init_set_order got %0d bad want 0", bad_set); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL init_done_pulses got %0d want 1", dones); end
        n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL init_stall_in_done got %0d low want 0", stall_bad); end
        n_checks++; if (outstanding !== 3'd0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL init_final got out=%0d err=%b want 0/0", outstanding, proto_err); end
    endtask

    // Credits exhaust after 4 issues; one ack re-opens the slot.
    task automatic test_credit_limit();
        int issued = 0, bad_set = 0;
        rst = 1'b1; step(); rst = 1'b0;
        sweep_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (sweep_valid && sweep_ready) begin
                if (sweep_set !== SET_BITS'(issued)) bad_set++;
                issued++;
            end
            step();
        end
        n_checks++; if (issued != 4 || bad_set != 0) begin n_fail++; $display("FAIL credit_issue got %0d issued %0d bad want 4/0", issued, bad_set); end
        n_checks++; if (outstanding !== 3'd4 || sweep_valid !== 1'b0) begin n_fail++; $display("FAIL credit_full got out=%0d valid=%b want 4/0", outstanding, sweep_valid); end
        sweep_ready = 1'b0; sweep_ack = 1'b1; step(); sweep_ack = 1'b0;
        n_checks++; if (sweep_valid !== 1'b1 || sweep_set !== 4'd4 || outstanding !== 3'd3) begin n_fail++; $display("FAIL credit_reopen got valid=%b set=%0d out=%0d want 1/4/3", sweep_valid, sweep_set, outstanding); end
    endtask

    task automatic test_issue_and_ack();
        sweep_ack = 1'b1; step();
        n_checks++; if (outstanding !== 3'd2 || sweep_set !== 4'd4) begin n_fail++; $display("FAIL ack_only got out=%0d set=%0d want 2/4", outstanding, sweep_set); end
        sweep_ready = 1'b1; step(); sweep_ack = 1'b0;
        n_checks++; if (outstanding !== 3'd2 || sweep_set !== 4'd5) begin n_fail++; $display("FAIL issue_and_ack got out=%0d set=%0d want 2/5", outstanding, sweep_set); end
    endtask

    task automatic drain_to_idle();
        int c = 0;
        sweep_ready = 1'b1;
        while (!flush_req_ready && c < 100) begin
            sweep_ack = (outstanding != '0);
            step();
            c++;
        end
        sweep_ack = 1'b0;
        n_checks++; if (flush_req_ready !== 1'b1) begin n_fail++; $display("FAIL drain_timeout got ready=%b want 1", flush_req_ready); end
    endtask

    // Flush sweep with a second request held high during the sweep.
    task automatic test_flush();
        logic [2:0] pipe = 3'b000;
        int issued = 0, dones = 0, bad_set = 0, ready_hi = 0, rst_stall_hi = 0;
        logic hs, reached = 1'b0;
        flush_req_valid = 1'b1; step();
        n_checks++; if (flush_stall !== 1'b1 || flush_req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_accept got stall=%b ready=%b want 1/0", flush_stall, flush_req_ready); end
        n_checks++; if (sweep_valid !== 1'b1 || sweep_is_rst !== 1'b0 || sweep_set !== 4'd0) begin n_fail++; $display("FAIL flush_first_op got v=%b r=%b s=%0d want 1/0/0", sweep_valid, sweep_is_rst, sweep_set); end
        for (int c = 0; c < 60; c++) begin
            if (flush_req_ready) begin reached = 1'b1; break; end
            if (rst_stall) rst_stall_hi++;
            if (flush_done) dones++;
            hs = sweep_valid && sweep_ready;
            if (hs) begin
                if (sweep_set !== SET_BITS'(issued) || sweep_is_rst !== 1'b0) bad_set++;
                issued++;
            end
            sweep_ack = pipe[2];
            pipe = {pipe[1:0], hs};
            step();
        end
        flush_req_valid = 1'b0; sweep_ack = 1'b0;
        n_checks++; if (!reached) begin n_fail++; $display("FAIL flush_timeout got ready=%b want 1", flush_req_ready); end
        n_checks++; if (issued != 16 || bad_set != 0) begin n_fail++; $display("FAIL flush_ops got %0d issued %0d bad want 16/0", issued, bad_set); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL flush_done_pulses got %0d want 1", dones); end
        n_checks++; if (flush_stall !== 1'b0 || rst_stall_hi != 0 || ready_hi != 0) begin n_fail++; $display("FAIL flush_stalls got fstall=%b rstall_hi=%0d want 0/0", flush_stall, rst_stall_hi); end
    endtask

    // Soft reset while a flush is offering set 7.
    task automatic test_soft_restart();
        logic found = 1'b0;
        flush_req_valid = 1'b1; step(); flush_req_valid = 1'b0;
        sweep_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (sweep_valid && sweep_set == 4'd7) begin found = 1'b1; break; end
            sweep_ack = (outstanding != '0);
            step();
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL restart_set7_timeout got set=%0d want 7", sweep_set); end
        rst_state = 1'b1; sweep_ack = 1'b1; step(); rst_state = 1'b0;
        n_checks++; if (flush_stall !== 1'b0 || rst_stall !== 1'b1 || sweep_valid !== 1'b0) begin n_fail++; $display("FAIL restart_state got f=%b r=%b v=%b want 0/1/0", flush_stall, rst_stall, sweep_valid); end
        n_checks++; if (outstanding !== 3'd0 || sweep_set !== 4'd0 || sweep_is_rst !== 1'b1) begin n_fail++; $display("FAIL restart_regs got out=%0d set=%0d r=%b want 0/0/1", outstanding, sweep_set, sweep_is_rst); end
        step(); sweep_ack = 1'b0;
        n_checks++; if (outstanding !== 3'd0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL restart_stale_ack got out=%0d err=%b want 0/0", outstanding, proto_err); end
        n_checks++; if (sweep_valid !== 1'b1 || sweep_set !== 4'd0 || sweep_is_rst !== 1'b1) begin n_fail++; $display("FAIL restart_offer got v=%b s=%0d r=%b want 1/0/1", sweep_valid, sweep_set, sweep_is_rst); end
    endtask

    // Ack with no credit, then a backpressured offer held for 5 cycles.
    task automatic test_proto_err_and_hold();
        int unstable = 0;
        sweep_ready = 1'b0; sweep_ack = 1'b1; step(); sweep_ack = 1'b0;
        n_checks++; if (proto_err !== 1'b1 || outstanding !== 3'd0) begin n_fail++; $display("FAIL proto_err_set got err=%b out=%0d want 1/0", proto_err, outstanding); end
        for (int c = 0; c < 5; c++) begin
            step();
            if (sweep_valid !== 1'b1 || sweep_set !== 4'd0 || proto_err !== 1'b1) unstable++;
        end
        n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL hold_stable got %0d unstable cycles want 0", unstable); end
        rst_state = 1'b1; step(); rst_state = 1'b0;
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_err_clear got %b want 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_credit_limit();
        test_issue_and_ack();
        drain_to_idle();
        test_flush();
        test_soft_restart();
        test_proto_err_and_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
